// File: rtl/y86_stage_sequencer.sv
// Y86-64 SEQ multi-cycle controller: owns the PC, sequences one-hot
// stage enables, waits on data memory and reports architectural status.
module y86_stage_sequencer #(
  parameter logic [63:0] RESET_PC    = 64'd32,
  parameter int          CNT_W       = 32,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_ready,
  input  logic             dmem_error,
  input  logic [63:0]      updated_pc,
  output logic [63:0]      pc,
  output logic             en_fetch,
  output logic             en_decode,
  output logic             en_exec,
  output logic             en_mem,
  output logic             en_wb,
  output logic             en_pcup,
  output logic [2:0]       stat,
  output logic             running,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t        state, state_nx;
  logic [2:0]    stat_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          ret_inc;
  logic          pc_ld;
  logic          mem_op;

  assign mem_op = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

  always_comb begin
    state_nx = state;
    stat_nx  = stat;
    tcnt_nx  = tcnt;
    ret_inc  = 1'b0;
    pc_ld    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (imem_error) begin
          state_nx = S_FAULT;
          stat_nx  = 3'd3;
        end else if (!instr_valid || icode > 4'hB) begin
          state_nx = S_FAULT;
          stat_nx  = 3'd4;
        end else if (icode == 4'h0) begin
          state_nx = S_HALTED;
          stat_nx  = 3'd2;
          ret_inc  = 1'b1;
        end else begin
          state_nx = S_DECODE;
        end
      end
      S_DECODE: state_nx = S_EXECUTE;
      S_EXECUTE: begin
        state_nx = mem_op ? S_MEMORY : S_WRITEBACK;
        tcnt_nx  = '0;
      end
      S_MEMORY: begin
        // a late ready still beats the timeout on the same cycle
        if (dmem_ready) begin
          if (dmem_error) begin
            state_nx = S_FAULT;
            stat_nx  = 3'd3;
          end else begin
            state_nx = S_WRITEBACK;
          end
        end else if (tcnt == T_LAST) begin
          state_nx = S_FAULT;
          stat_nx  = 3'd3;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      S_WRITEBACK: state_nx = S_PCUPD;
      S_PCUPD: begin
        state_nx = S_FETCH;
        pc_ld    = 1'b1;
        ret_inc  = 1'b1;
      end
      default: ;
    endcase
  end

  assign en_fetch  = (state == S_FETCH);
  assign en_decode = (state == S_DECODE);
  assign en_exec   = (state == S_EXECUTE);
  assign en_mem    = (state == S_MEMORY);
  assign en_wb     = (state == S_WRITEBACK);
  assign en_pcup   = (state == S_PCUPD);
  assign running   = en_fetch | en_decode | en_exec |
                     en_mem | en_wb | en_pcup;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      stat        <= 3'd1;
      tcnt        <= '0;
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      state <= state_nx;
      stat  <= stat_nx;
      tcnt  <= tcnt_nx;
      if (pc_ld) pc <= updated_pc;
      if (running && cycle_cnt != CNT_MAX)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (ret_inc && retired_cnt != CNT_MAX)
        retired_cnt <= retired_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Directed plus random bench for y86_stage_sequencer against an
// instruction-level model of stage order, PC, status and counters.
module tb_y86_stage_sequencer;

  localparam int MEM_T = 16;
  localparam int MAXC  = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic        instr_valid = 1'b1;
  logic        imem_error = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        dmem_error = 1'b0;
  logic [63:0] updated_pc = '0;
  logic [63:0] pc;
  logic        en_fetch, en_decode, en_exec;
  logic        en_mem, en_wb, en_pcup;
  logic [2:0]  stat;
  logic        running;
  logic [7:0]  cycle_cnt, retired_cnt;

  y86_stage_sequencer #(
    .RESET_PC(64'd32),
    .CNT_W(8),
    .MEM_TIMEOUT(MEM_T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .dmem_ready(dmem_ready),
    .dmem_error(dmem_error), .updated_pc(updated_pc),
    .pc(pc), .en_fetch(en_fetch), .en_decode(en_decode),
    .en_exec(en_exec), .en_mem(en_mem), .en_wb(en_wb),
    .en_pcup(en_pcup), .stat(stat), .running(running),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  logic [63:0] epc;
  int ecyc, eret, estat;
  bit erun, term;

  localparam logic [5:0] F = 6'b000001, D = 6'b000010;
  localparam logic [5:0] E = 6'b000100, M = 6'b001000;
  localparam logic [5:0] W = 6'b010000, P = 6'b100000;

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  function automatic logic [5:0] ens();
    return {en_pcup, en_wb, en_mem, en_exec, en_decode, en_fetch};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (erun) ecyc = sat(ecyc);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [5:0] en_e);
    chk({tag, "_en"}, ens(), en_e);
    chk({tag, "_run"}, running, erun);
    chk({tag, "_stat"}, stat, estat);
    chk({tag, "_pc"}, pc, epc);
    chk({tag, "_cyc"}, cycle_cnt, ecyc);
    chk({tag, "_ret"}, retired_cnt, eret);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    epc = 64'd32; ecyc = 0; eret = 0;
    estat = 1; erun = 0; term = 0;
    chk_state("reset", 6'b0);
    rst_n = 1'b1;
    #2;
  endtask

  task automatic do_start();
    chk_state("idle", 6'b0);
    tick();
    chk_state("idle_hold", 6'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    erun = 1;
  endtask

  task automatic chk_term();
    erun = 0;
    chk_state("term", 6'b0);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    tick();
    chk_state("term_frozen", 6'b0);
  endtask

  task automatic instr(input logic [3:0] ic, input bit v,
                       input bit ie, input int d, input bit me,
                       input logic [63:0] upc);
    bit is_mem;
    icode = ic; instr_valid = v; imem_error = ie;
    dmem_ready = 1'b0; dmem_error = 1'b0;
    updated_pc = upc;
    is_mem = (ic == 4'h4) || (ic == 4'h5) || (ic >= 4'h8 && ic <= 4'hB);
    term = 0;
    chk_state("fetch", F);
    if (ie) begin estat = 3; term = 1; end
    else if (!v || ic > 4'hB) begin estat = 4; term = 1; end
    else if (ic == 4'h0) begin
      estat = 2; term = 1; eret = sat(eret);
    end
    tick();
    if (term) begin chk_term(); return; end
    chk_state("decode", D); tick();
    chk_state("exec", E); tick();
    if (is_mem) begin
      for (int i = 1; i <= MEM_T; i++) begin
        chk_state("mem", M);
        if (i == d) begin dmem_ready = 1'b1; dmem_error = me; end
        tick();
        dmem_ready = 1'b0; dmem_error = 1'b0;
        if (i == d) break;
      end
      if (d > MEM_T || me) begin
        estat = 3; term = 1;
        chk_term();
        return;
      end
    end
    chk_state("wb", W); tick();
    chk_state("pcup", P);
    epc = upc; eret = sat(eret);
    tick();
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    do_start();
    instr(4'h3, 1, 0, 0, 0, 64'd42);
    chk("t1_pc", pc, 64'd42);
    chk("t1_cyc", cycle_cnt, 64'd5);
    chk("t1_ret", retired_cnt, 64'd1);
    instr(4'h5, 1, 0, 3, 0, 64'd52);
    chk("t2_cyc", cycle_cnt, 64'd13);
    chk("t2_ret", retired_cnt, 64'd2);

    do_reset(); do_start();
    instr(4'h0, 1, 0, 0, 0, 64'd99);
    chk("t3_pc", pc, 64'd32);
    chk("t3_stat", stat, 64'd2);
    chk("t3_ret", retired_cnt, 64'd1);

    do_reset(); do_start();
    instr(4'h2, 0, 1, 0, 0, 64'd0);
    chk("t4_adr", stat, 64'd3);
    do_reset(); do_start();
    instr(4'h2, 0, 0, 0, 0, 64'd0);
    chk("t4_ins", stat, 64'd4);
    do_reset(); do_start();
    instr(4'hC, 1, 0, 0, 0, 64'd0);
    chk("t4_icode", stat, 64'd4);

    do_reset(); do_start();
    instr(4'hA, 1, 0, MEM_T + 1, 0, 64'd0);
    chk("t5_tmo", stat, 64'd3);
    chk("t5_cyc", cycle_cnt, 64'd19);
    do_reset(); do_start();
    instr(4'hA, 1, 0, MEM_T, 0, 64'd77);
    chk("t5_edge_pc", pc, 64'd77);
    instr(4'h8, 1, 0, 2, 1, 64'd0);
    chk("t5_derr", stat, 64'd3);

    do_reset(); do_start();
    icode = 4'h5; instr_valid = 1; imem_error = 0;
    dmem_ready = 0; dmem_error = 0;
    chk_state("t6_f", F); tick();
    chk_state("t6_d", D); tick();
    chk_state("t6_e", E); tick();
    chk_state("t6_m", M); tick();
    chk_state("t6_m2", M);
    do_reset();

    do_start();
    for (int n = 0; n < 270; n++) begin
      instr(4'($urandom_range(1, 11)), 1, 0,
            $urandom_range(1, 4), 0, {$urandom, $urandom});
    end
    chk("sat_cyc", cycle_cnt, 64'd255);
    chk("sat_ret", retired_cnt, 64'd255);

    do_reset(); do_start();
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 15);
      case (r)
        0: instr(4'($urandom), $urandom_range(0, 1), 1, 1, 0, 64'd0);
        1: instr(4'($urandom_range(1, 11)), 0, 0, 1, 0, 64'd0);
        2: instr(4'($urandom_range(12, 15)), 1, 0, 1, 0, 64'd0);
        3: instr(4'h0, 1, 0, 1, 0, 64'd0);
        4: instr(4'h8, 1, 0, MEM_T + 1, 0, 64'd0);
        5: instr(4'h9, 1, 0, $urandom_range(1, MEM_T), 1, 64'd0);
        default: instr(4'($urandom_range(1, 11)), 1, 0,
                       $urandom_range(1, MEM_T), 0,
                       {$urandom, $urandom});
      endcase
      if (term) begin do_reset(); do_start(); end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
